// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT tick sequencer.
// CLINT register offsets, the disarm value, the sequencer state encoding,
// the bus request record and the period normalisation helper.
package clint_pkg;

    localparam logic [31:0] MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI    = 32'h0000_BFFC;

    // Writing this to mtimecmp pushes the compare point out of reach.
    localparam logic [31:0] DISARM_VAL  = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_HI1    = 4'd1,
        RD_LO     = 4'd2,
        RD_HI2    = 4'd3,
        CALC      = 4'd4,
        WR_HI_MAX = 4'd5,
        WR_LO     = 4'd6,
        WR_HI     = 4'd7,
        ARMED     = 4'd8,
        DIS_HI    = 4'd9,
        DIS_LO    = 4'd10
    } seq_state_e;

    // One single-beat bus access handed from the sequencer to the bus engine.
    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_req_t;

    // A zero period would re-arm on the current count; treat it as one count.
    function automatic logic [63:0] norm_period(input logic [63:0] p);
        return (p == 64'd0) ? 64'd1 : p;
    endfunction

endpackage

// File: rtl/clint_wb_single_master.sv
// Single-transaction Wishbone master engine.
// Accepts one {adr, we, dat} request pulse while idle, holds stb/cyc until
// ack is sampled, then drops stb/cyc for at least one cycle. Read data is
// captured on the ack cycle.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_i, req_*_i           request pulse and its address / write / data
//   done_o                   high in the cycle the access is acknowledged
//   rdata_o                  read data: live on the ack cycle, held after
//   wb_*                     Wishbone master signals (all registered)
module clint_wb_single_master (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] req_adr_i,
    input  logic        req_we_i,
    input  logic [31:0] req_dat_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    logic        stb_r;
    logic        we_r;
    logic [3:0]  sel_r;
    logic [31:0] adr_r;
    logic [31:0] dat_r;
    logic [31:0] rdata_r;

    // Bus strobe / address / data registers and read-data capture.
    // A request is only accepted when stb is low, so the cycle after an ack
    // is always a gap cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            sel_r   <= 4'h0;
            adr_r   <= 32'h0000_0000;
            dat_r   <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else if (stb_r) begin
            if (wb_ack_i) begin
                stb_r   <= 1'b0;
                we_r    <= 1'b0;
                sel_r   <= 4'h0;
                rdata_r <= wb_dat_i;
            end else begin
                stb_r   <= 1'b1;
            end
        end else if (req_i) begin
            stb_r <= 1'b1;
            we_r  <= req_we_i;
            sel_r <= 4'hF;
            adr_r <= req_adr_i;
            dat_r <= req_dat_i;
        end else begin
            stb_r <= 1'b0;
        end
    end

    assign done_o   = stb_r & wb_ack_i;
    assign rdata_o  = done_o ? wb_dat_i : rdata_r;
    assign wb_adr_o = adr_r;
    assign wb_dat_o = dat_r;
    assign wb_we_o  = we_r;
    assign wb_sel_o = sel_r;
    assign wb_stb_o = stb_r;
    assign wb_cyc_o = stb_r;

endmodule

// File: rtl/clint_tick_sequencer.sv
// Periodic machine-timer tick sequencer (second Wishbone master to the CLINT).
// On enable it reads mtime tear-free (hi, lo, hi) and arms
// mtimecmp = mtime + period. On each timer interrupt it re-arms drift-free
// with mtimecmp += period and pulses tick_o. mtimecmp hi is parked at all-ones
// before the lo half changes so a half-written compare can never match.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   enable_i         1 = keep ticking, 0 = disarm
//   period_i         tick period in mtime counts (0 behaves as 1)
//   timer_irq_i      CLINT machine-timer interrupt level
//   wb_*             Wishbone master port towards the CLINT
//   tick_o           one-cycle pulse per serviced interrupt
//   armed_o          mtimecmp holds a valid target
//   tick_count_o     serviced ticks since reset, wrapping
module clint_tick_sequencer
    import clint_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int          PERIOD_W   = 32,
    parameter int          SETTLE_CYC = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                timer_irq_i,
    output logic [31:0]         wb_adr_o,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    output logic                wb_we_o,
    output logic [3:0]          wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_ack_i,
    output logic                tick_o,
    output logic                armed_o,
    output logic [31:0]         tick_count_o
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC);

    seq_state_e  state_r;
    logic [31:0] hi1_r;
    logic [31:0] lo_r;
    logic [63:0] target_r;
    logic [63:0] period_r;
    logic [7:0]  settle_r;
    logic        armed_r;
    logic        tick_r;
    logic [31:0] tick_cnt_r;
    logic        req_r;
    bus_req_t    req_q_r;

    logic        eng_done_s;
    logic [31:0] eng_rdata_s;
    logic [63:0] period_in_s;

    assign period_in_s = norm_period(64'(period_i));

    // The bus access a state performs, issued one cycle before the engine
    // needs it so back-to-back accesses keep a single-cycle gap.
    function automatic bus_req_t access_for(input seq_state_e st, input logic [63:0] tgt);
        bus_req_t r;
        r.adr = CLINT_BASE + MTIME_HI;
        r.we  = 1'b0;
        r.dat = 32'h0000_0000;
        case (st)
            RD_HI1, RD_HI2: begin
                r.adr = CLINT_BASE + MTIME_HI;
                r.we  = 1'b0;
                r.dat = 32'h0000_0000;
            end
            RD_LO: begin
                r.adr = CLINT_BASE + MTIME_LO;
                r.we  = 1'b0;
                r.dat = 32'h0000_0000;
            end
            WR_HI_MAX, DIS_HI: begin
                r.adr = CLINT_BASE + MTIMECMP_HI;
                r.we  = 1'b1;
                r.dat = DISARM_VAL;
            end
            WR_LO: begin
                r.adr = CLINT_BASE + MTIMECMP_LO;
                r.we  = 1'b1;
                r.dat = tgt[31:0];
            end
            WR_HI: begin
                r.adr = CLINT_BASE + MTIMECMP_HI;
                r.we  = 1'b1;
                r.dat = tgt[63:32];
            end
            DIS_LO: begin
                r.adr = CLINT_BASE + MTIMECMP_LO;
                r.we  = 1'b1;
                r.dat = DISARM_VAL;
            end
            default: begin
                r.adr = CLINT_BASE + MTIME_HI;
                r.we  = 1'b0;
                r.dat = 32'h0000_0000;
            end
        endcase
        return r;
    endfunction

    // Sequencer FSM with registered tick/armed/count outputs and bus requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            hi1_r      <= 32'h0000_0000;
            lo_r       <= 32'h0000_0000;
            target_r   <= 64'd0;
            period_r   <= 64'd0;
            settle_r   <= 8'd0;
            armed_r    <= 1'b0;
            tick_r     <= 1'b0;
            tick_cnt_r <= 32'd0;
            req_r      <= 1'b0;
            req_q_r    <= '0;
        end else begin
            req_r  <= 1'b0;
            tick_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable_i) begin
                        period_r <= period_in_s;
                        req_r    <= 1'b1;
                        req_q_r  <= access_for(RD_HI1, target_r);
                        state_r  <= RD_HI1;
                    end
                end
                RD_HI1: begin
                    if (eng_done_s) begin
                        hi1_r   <= eng_rdata_s;
                        req_r   <= 1'b1;
                        req_q_r <= access_for(RD_LO, target_r);
                        state_r <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (eng_done_s) begin
                        lo_r    <= eng_rdata_s;
                        req_r   <= 1'b1;
                        req_q_r <= access_for(RD_HI2, target_r);
                        state_r <= RD_HI2;
                    end
                end
                RD_HI2: begin
                    if (eng_done_s) begin
                        req_r <= 1'b1;
                        if (eng_rdata_s != hi1_r) begin
                            // lo wrapped between the reads: retry lo under the new hi.
                            hi1_r   <= eng_rdata_s;
                            req_q_r <= access_for(RD_LO, target_r);
                            state_r <= RD_LO;
                        end else begin
                            // The park write does not depend on the target, so it
                            // is launched while CALC computes.
                            req_q_r <= access_for(WR_HI_MAX, target_r);
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    target_r <= {hi1_r, lo_r} + period_r;
                    state_r  <= WR_HI_MAX;
                end
                WR_HI_MAX: begin
                    if (eng_done_s) begin
                        req_r   <= 1'b1;
                        req_q_r <= access_for(WR_LO, target_r);
                        state_r <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (eng_done_s) begin
                        req_r   <= 1'b1;
                        req_q_r <= access_for(WR_HI, target_r);
                        state_r <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (eng_done_s) begin
                        armed_r  <= 1'b1;
                        settle_r <= SETTLE_INIT;
                        state_r  <= ARMED;
                    end
                end
                ARMED: begin
                    if (!enable_i) begin
                        // Disable has priority over a coincident interrupt.
                        armed_r <= 1'b0;
                        req_r   <= 1'b1;
                        req_q_r <= access_for(DIS_HI, target_r);
                        state_r <= DIS_HI;
                    end else if (settle_r != 8'd0) begin
                        // The CLINT interrupt may still reflect the old compare.
                        settle_r <= settle_r - 8'd1;
                    end else if (timer_irq_i) begin
                        tick_r     <= 1'b1;
                        tick_cnt_r <= tick_cnt_r + 32'd1;
                        armed_r    <= 1'b0;
                        period_r   <= period_in_s;
                        target_r   <= target_r + period_in_s;
                        req_r      <= 1'b1;
                        req_q_r    <= access_for(WR_HI_MAX, target_r);
                        state_r    <= WR_HI_MAX;
                    end
                end
                DIS_HI: begin
                    if (eng_done_s) begin
                        req_r   <= 1'b1;
                        req_q_r <= access_for(DIS_LO, target_r);
                        state_r <= DIS_LO;
                    end
                end
                DIS_LO: begin
                    if (eng_done_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    armed_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    clint_wb_single_master u_bus (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_r),
        .req_adr_i (req_q_r.adr),
        .req_we_i  (req_q_r.we),
        .req_dat_i (req_q_r.dat),
        .done_o    (eng_done_s),
        .rdata_o   (eng_rdata_s),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_ack_i  (wb_ack_i)
    );

    assign tick_o       = tick_r;
    assign armed_o      = armed_r;
    assign tick_count_o = tick_cnt_r;

endmodule

// File: tb/tb_clint_tick_sequencer.sv
// Self-checking bench for clint_tick_sequencer with a behavioural CLINT slave.
module tb_clint_tick_sequencer;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic [63:0] mtime;
        logic [31:0] period;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd0;
    logic        timer_irq;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        wb_we, wb_stb, wb_cyc;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0;
    logic        tick;
    logic        armed;
    logic [31:0] tick_count;

    // CLINT model state
    logic [63:0] mtime = 64'd0;
    logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        mtime_run = 1'b0;
    logic        mtime_ld = 1'b0;
    logic [63:0] mtime_ld_val = 64'd0;
    logic        irq_en = 1'b0;
    logic        force_irq = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val [5];
    int          ovr_idx = 0;
    logic [31:0] rdat = 32'd0;

    bus_t        log_q[$];
    int          tick_q[$];
    int          cyc_cnt = 0;
    int          proto_err = 0;
    logic        ack_prev = 1'b0;
    logic        tick_prev = 1'b0;

    int          checks = 0;
    int          errors = 0;

    assign timer_irq = (irq_en && (mtime >= mtimecmp)) || force_irq;
    assign wb_dat_i  = rdat;

    clint_tick_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .period_i     (period),
        .timer_irq_i  (timer_irq),
        .wb_adr_o     (wb_adr),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_we_o      (wb_we),
        .wb_sel_o     (wb_sel),
        .wb_stb_o     (wb_stb),
        .wb_cyc_o     (wb_cyc),
        .wb_ack_i     (wb_ack),
        .tick_o       (tick),
        .armed_o      (armed),
        .tick_count_o (tick_count)
    );

    always #5 clk = ~clk;

    // mtime counter
    always @(posedge clk) begin
        if (mtime_ld) mtime <= mtime_ld_val;
        else if (mtime_run) mtime <= mtime + 64'd1;
    end

    // Slave: ack one cycle after stb, read data, mtimecmp writes, access log
    always @(posedge clk) begin
        wb_ack <= wb_stb && !wb_ack;
        if (!ovr_en) ovr_idx <= 0;
        if (wb_stb && !wb_ack && !wb_we) begin
            if (ovr_en && ovr_idx < 5) begin
                rdat    <= ovr_val[ovr_idx];
                ovr_idx <= ovr_idx + 1;
            end else if (wb_adr == 32'h0200_BFFC) rdat <= mtime[63:32];
            else if (wb_adr == 32'h0200_BFF8) rdat <= mtime[31:0];
            else rdat <= 32'h0;
        end
        if (wb_stb && wb_ack) begin
            log_q.push_back({wb_adr, wb_we, wb_we ? wb_dat_o : wb_dat_i});
            if (wb_we && wb_adr == 32'h0200_4000) mtimecmp[31:0] <= wb_dat_o;
            if (wb_we && wb_adr == 32'h0200_4004) mtimecmp[63:32] <= wb_dat_o;
        end
    end

    // Protocol and tick monitors
    always @(posedge clk) begin
        cyc_cnt   <= cyc_cnt + 1;
        ack_prev  <= wb_stb && wb_ack;
        tick_prev <= tick;
        if (tick) tick_q.push_back(cyc_cnt);
        if ((ack_prev && wb_stb) || (wb_cyc !== wb_stb) ||
            (wb_stb && wb_sel !== 4'hF) || (tick && tick_prev))
            proto_err <= proto_err + 1;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic bus_t log_at(input int i);
        bus_t b;
        if (i < log_q.size()) b = log_q[i];
        else b = {32'hDEAD_DEAD, 1'b0, 32'hDEAD_DEAD};
        return b;
    endfunction

    task automatic expect_bus(input string name, input int idx, input logic [31:0] adr,
                              input logic we, input logic [31:0] dat);
        bus_t b;
        b = log_at(idx);
        chk(name, {b.adr, 32'(b.we), b.dat}, {adr, 32'(we), dat});
    endtask

    task automatic load_mtime(input logic [63:0] v);
        @(negedge clk);
        mtime_ld_val = v;
        mtime_ld = 1'b1;
        @(negedge clk);
        mtime_ld = 1'b0;
    endtask

    task automatic wait_armed(input string name, input int budget, output int n);
        n = 0;
        while (armed !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (armed !== 1'b1) fail_timeout(name);
    endtask

    task automatic wait_log(input string name, input int target, input int budget);
        int n = 0;
        while (log_q.size() < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (log_q.size() < target) fail_timeout(name);
    endtask

    task automatic disarm_check(input string name);
        int base;
        @(negedge clk);
        enable = 1'b0;
        base = log_q.size();
        wait_log({name, "_dis"}, base + 2, 40);
        repeat (2) @(posedge clk);
        #1;
        expect_bus({name, "_dis_hi"}, base, 32'h0200_4004, 1'b1, 32'hFFFF_FFFF);
        expect_bus({name, "_dis_lo"}, base + 1, 32'h0200_4000, 1'b1, 32'hFFFF_FFFF);
        chk({name, "_disarmed"}, 96'(armed), 96'd0);
        chk({name, "_bus_idle"}, 96'(wb_stb), 96'd0);
    endtask

    initial begin
        vec_t        vecs [5];
        int          n;
        int          base;
        bus_t        e1, e2;
        logic [63:0] first_target;
        int          ticks_before;
        bit          tick_seen;

        // period 0 first: checks the restart after reset and the 0 -> 1 mapping
        vecs[0] = '{64'h0000_0000_0000_0777, 32'd0,          32'h0000_0778, 32'h0000_0000};
        vecs[1] = '{64'h0000_0000_0000_0050, 32'd100,        32'h0000_00B4, 32'h0000_0000};
        vecs[2] = '{64'h0000_0000_FFFF_FF00, 32'h0000_0200,  32'h0000_0100, 32'h0000_0001};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'd2,          32'h0000_0001, 32'h0000_0000};
        vecs[4] = '{64'h0000_0005_0000_0010, 32'h8000_0000,  32'h8000_0010, 32'h0000_0005};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb_cyc_we", {93'd0, wb_stb, wb_cyc, wb_we}, 96'd0);
        chk("rst_sel", 96'(wb_sel), 96'd0);
        chk("rst_adr_dat", {32'd0, wb_adr, wb_dat_o}, 96'd0);
        chk("rst_tick_armed", {94'd0, tick, armed}, 96'd0);
        chk("rst_count", 96'(tick_count), 96'd0);
        @(negedge clk);
        rst = 1'b0;

        // Periodic ticks against a running mtime
        load_mtime(64'd0);
        @(negedge clk);
        mtime_run = 1'b1;
        irq_en    = 1'b1;
        period    = 32'd1000;
        enable    = 1'b1;
        base      = log_q.size();
        wait_armed("tick_arm", 100, n);
        e1 = log_at(base + 1);
        e2 = log_at(base + 2);
        first_target = {e2.dat, e1.dat} + 64'd1000;
        expect_bus("tick_arm_lo", base + 4, 32'h0200_4000, 1'b1, first_target[31:0]);
        n = 0;
        while (tick_q.size() < 5 && n < 7000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tick_q.size() < 5) fail_timeout("tick_wait");
        for (int i = 0; i < 4; i++)
            chk($sformatf("tick_interval_%0d", i), 96'(tick_q[i+1] - tick_q[i]), 96'd1000);
        wait_armed("tick_rearm", 60, n);
        chk("tick_count_5", 96'(tick_count), 96'd5);
        chk("mtimecmp_after_5", 96'(mtimecmp), 96'(first_target + 64'd5000));

        // Reset while the 6th re-arm is driving WR_LO
        n = 0;
        @(negedge clk);
        while (!(wb_stb && wb_we && wb_adr == 32'h0200_4000) && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (!(wb_stb && wb_we && wb_adr == 32'h0200_4000)) fail_timeout("wr_lo_wait");
        chk("tick_count_6", 96'(tick_count), 96'd6);
        rst = 1'b1;
        #1;
        chk("midrst_stb_cyc", {94'd0, wb_stb, wb_cyc}, 96'd0);
        chk("midrst_armed", 96'(armed), 96'd0);
        chk("midrst_count", 96'(tick_count), 96'd0);
        mtime_run = 1'b0;
        irq_en    = 1'b0;
        enable    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table of arm/disarm vectors against a frozen mtime
        for (int i = 0; i < 5; i++) begin
            load_mtime(vecs[i].mtime);
            @(negedge clk);
            period = vecs[i].period;
            enable = 1'b1;
            base   = log_q.size();
            wait_armed($sformatf("v%0d_arm", i), 60, n);
            chk($sformatf("v%0d_latency", i), 96'(n), 96'd19);
            expect_bus($sformatf("v%0d_rd_hi1", i), base,     32'h0200_BFFC, 1'b0, vecs[i].mtime[63:32]);
            expect_bus($sformatf("v%0d_rd_lo", i),  base + 1, 32'h0200_BFF8, 1'b0, vecs[i].mtime[31:0]);
            expect_bus($sformatf("v%0d_rd_hi2", i), base + 2, 32'h0200_BFFC, 1'b0, vecs[i].mtime[63:32]);
            expect_bus($sformatf("v%0d_wr_max", i), base + 3, 32'h0200_4004, 1'b1, 32'hFFFF_FFFF);
            expect_bus($sformatf("v%0d_wr_lo", i),  base + 4, 32'h0200_4000, 1'b1, vecs[i].exp_lo);
            expect_bus($sformatf("v%0d_wr_hi", i),  base + 5, 32'h0200_4004, 1'b1, vecs[i].exp_hi);
            chk($sformatf("v%0d_nacc", i), 96'(log_q.size() - base), 96'd6);
            disarm_check($sformatf("v%0d", i));
        end

        // Torn mtime read: hi changes between the two hi reads
        ovr_val[0] = 32'h0000_0000;
        ovr_val[1] = 32'hFFFF_FFFE;
        ovr_val[2] = 32'h0000_0001;
        ovr_val[3] = 32'h0000_0003;
        ovr_val[4] = 32'h0000_0001;
        load_mtime(64'd0);
        @(negedge clk);
        ovr_en = 1'b1;
        period = 32'h10;
        enable = 1'b1;
        base   = log_q.size();
        wait_armed("tear_arm", 80, n);
        expect_bus("tear_rd_hi1", base,     32'h0200_BFFC, 1'b0, 32'h0000_0000);
        expect_bus("tear_rd_lo",  base + 1, 32'h0200_BFF8, 1'b0, 32'hFFFF_FFFE);
        expect_bus("tear_rd_hi2", base + 2, 32'h0200_BFFC, 1'b0, 32'h0000_0001);
        expect_bus("tear_rd_lo2", base + 3, 32'h0200_BFF8, 1'b0, 32'h0000_0003);
        expect_bus("tear_rd_hi3", base + 4, 32'h0200_BFFC, 1'b0, 32'h0000_0001);
        expect_bus("tear_wr_max", base + 5, 32'h0200_4004, 1'b1, 32'hFFFF_FFFF);
        expect_bus("tear_wr_lo",  base + 6, 32'h0200_4000, 1'b1, 32'h0000_0013);
        expect_bus("tear_wr_hi",  base + 7, 32'h0200_4004, 1'b1, 32'h0000_0001);
        chk("tear_nacc", 96'(log_q.size() - base), 96'd8);
        disarm_check("tear");
        ovr_en = 1'b0;

        // Disable in the same cycle as the interrupt: disable wins, no tick
        load_mtime(64'h100);
        @(negedge clk);
        period = 32'h40;
        enable = 1'b1;
        wait_armed("dirq_arm", 60, n);
        repeat (4) @(negedge clk);
        ticks_before = tick_q.size();
        enable    = 1'b0;
        force_irq = 1'b1;
        base      = log_q.size();
        tick_seen = 1'b0;
        n = 0;
        while (log_q.size() < base + 2 && n < 40) begin
            @(posedge clk);
            #1;
            if (tick) tick_seen = 1'b1;
            n++;
        end
        if (log_q.size() < base + 2) fail_timeout("dirq_dis");
        force_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dirq_no_tick", 96'(tick_seen), 96'd0);
        chk("dirq_tick_q", 96'(tick_q.size() - ticks_before), 96'd0);
        chk("dirq_count", 96'(tick_count), 96'd0);
        expect_bus("dirq_dis_hi", base,     32'h0200_4004, 1'b1, 32'hFFFF_FFFF);
        expect_bus("dirq_dis_lo", base + 1, 32'h0200_4000, 1'b1, 32'hFFFF_FFFF);
        chk("dirq_armed", 96'(armed), 96'd0);
        chk("dirq_bus_idle", 96'(wb_stb), 96'd0);

        chk("protocol", 96'(proto_err), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint_tick_sequencer.md
Name: clint_tick_sequencer

Overview:
Wishbone master that programs the CLINT to produce a periodic machine-timer tick without CPU involvement. On enable it reads mtime tear-free and writes mtimecmp = mtime + period. On each timer interrupt it re-arms drift-free, with mtimecmp += period, and emits a one-cycle tick pulse. It sits beside the CPU as a second bus master, behind the system Wishbone arbiter, targeting the CLINT slave.

Parameters:
CLINT_BASE, 32'h0200_0000, CLINT base address; offsets: mtimecmp lo/hi 0x4000/0x4004, mtime lo/hi 0xBFF8/0xBFFC
PERIOD_W, 32, width of period_i, zero-extended to 64 bits
SETTLE_CYC, 2, cycles timer_irq_i is ignored after each arm completes

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
enable_i  in  1  level; 1 = keep ticking, 0 = disarm
period_i  in  PERIOD_W  tick period in mtime counts; value 0 is treated as 1
timer_irq_i  in  1  CLINT timer interrupt, level
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte select, always 4'hF when stb=1
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle, identical to wb_stb_o
wb_ack_i  in  1  acknowledge
tick_o  out  1  one-cycle pulse per serviced interrupt
armed_o  out  1  1 while mtimecmp holds a valid target
tick_count_o  out  32  serviced ticks since reset; wraps at 2^32

Behaviour:
- Reset: all outputs 0; FSM in IDLE; target_q = 0; period_q = 0. Async assert, sync-released usage. Reset mid-transaction drops stb/cyc immediately. The CLINT's own reset is independent.
- Bus rules:
  - One transaction at a time; all bus outputs are registered.
  - stb/cyc stay high until wb_ack_i is sampled high.
  - Read data is captured on the ack cycle.
  - stb/cyc are low for exactly one cycle after every ack, so each access takes at least 3 cycles.
  - No timeout.
- FSM states: IDLE, RD_HI1, RD_LO, RD_HI2, CALC, WR_HI_MAX, WR_LO, WR_HI, ARMED, DIS_HI, DIS_LO.
- IDLE: when enable_i = 1, latch period_q (0 maps to 1), then go to RD_HI1.
- RD_HI1 -> RD_LO -> RD_HI2 (mtime reads):
  - If hi2 != hi1: set hi1 = hi2 and repeat RD_LO.
  - Otherwise go to CALC.
- CALC (1 cycle): target_q = {hi1, lo} + period_q, 64-bit with carry, wrap modulo 2^64.
- Write sequence:
  - WR_HI_MAX writes mtimecmp_hi = FFFF_FFFF, preventing a spurious match.
  - WR_LO writes target_q[31:0].
  - WR_HI writes target_q[63:32].
  - Then go to ARMED with armed_o = 1.
- ARMED:
  - First SETTLE_CYC cycles: timer_irq_i is ignored.
  - If enable_i = 0: clear armed_o, go to DIS_HI.
  - Else if timer_irq_i = 1:
    - tick_o = 1 for one cycle and tick_count_o += 1.
    - Re-sample period_q, set target_q += period_q, go to WR_HI_MAX. No mtime read on re-arm.
  - If both enable_i = 0 and timer_irq_i = 1 in the same cycle, disable wins: no tick.
- DIS_HI / DIS_LO: write FFFF_FFFF to mtimecmp hi, then lo; then go to IDLE.
- Changes during a sequence:
  - enable_i falling outside ARMED and IDLE is acted on only after reaching ARMED.
  - period_i changes take effect only at the next sample point.
- A period shorter than the re-arm latency (about 12 cycles) yields back-to-back ticks. This is legal; no tick is lost or merged.

Decomposition:
- Package clint_pkg holds:
  - CLINT offset constants (MTIMECMP_LO/HI, MTIME_LO/HI).
  - The seq_state_e enum.
  - A DISARM_VAL = 32'hFFFF_FFFF constant.
- Sub-module clint_wb_single_master: a req/done single-transaction engine that owns the stb/ack/gap timing and the read-data capture. The FSM issues {addr, we, data} requests to it.

Test Plan:
- Enable with period = 100 against the real clint, mtime = 0x50 at read: expected bus sequence is RD 0x0200BFFC, 0x0200BFF8, 0x0200BFFC; WR 0x02004004 = FFFF_FFFF; WR 0x02004000 = lo + 100; WR 0x02004004 = 0. armed_o = 1 after the last ack.
- Model slave returns hi1 = 0, lo = FFFF_FFFE, hi2 = 1, then lo = 0x3 -> exactly one extra RD 0x0200BFF8; target = 0x1_0000_0003 + period.
- Period = 1000, real clint, 5 ticks -> tick_o pulses exactly 1000 cycles apart; mtimecmp = T0 + 1000k; tick_count_o = 5.
- target_q = 0x0000_0000_FFFF_FF00, period = 0x200 -> writes lo = 0x0000_0100, hi = 0x0000_0001.
- enable_i = 0 while ARMED; also enable_i = 0 in the same cycle as timer_irq_i = 1 -> writes FFFF_FFFF to 0x02004004 then 0x02004000; no tick_o; armed_o = 0; state IDLE.
- rst_i asserted while stb = 1 during WR_LO -> stb, cyc, armed_o and tick_count_o are 0 in the same cycle. Re-enabling restarts from RD_HI1; period_i = 0 then yields a target of mtime + 1.
